// File: rtl/hier_path_decoder_if.sv
// Path-stream handshake bundle: digit stream in, decoded leaf index out.
interface hier_path_decoder_if #(
  parameter int DIGIT_W = 4,
  parameter int IDX_W   = 21
);
  logic               in_valid;
  logic               in_ready;
  logic [DIGIT_W-1:0] in_digit;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [IDX_W-1:0]   out_index;
  logic [3:0]         out_depth;
  logic               out_error;

  modport master (
    output in_valid, in_digit, in_last, out_ready,
    input  in_ready, out_valid, out_index, out_depth, out_error
  );

  modport slave (
    input  in_valid, in_digit, in_last, out_ready,
    output in_ready, out_valid, out_index, out_depth, out_error
  );
endinterface

// File: rtl/hier_path_decoder.sv
// Reduces a root-first stream of child digits to a flat mixed-radix leaf index,
// depth and error flag; one result per path, held until the consumer takes it.
module hier_path_decoder #(
  parameter int FANOUT    = 5,
  parameter int MAX_DEPTH = 9,
  parameter int DIGIT_W   = 4,
  parameter int IDX_W     = 21
) (
  input logic                clk,
  input logic                rst,
  hier_path_decoder_if.slave bus
);
  typedef enum logic [1:0] {ACCUM, DRAIN, OUT} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [3:0]       depth_q, depth_d;
  logic             err_q, err_d;
  logic             accept, bad_digit;

  assign bus.in_ready = !rst && (state_q != OUT);
  assign accept       = bus.in_valid && bus.in_ready;
  // A digit past the depth cap is an error just like an out-of-range digit.
  assign bad_digit    = (bus.in_digit >= DIGIT_W'(FANOUT)) || (depth_q == 4'(MAX_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      idx_q   <= '0;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    depth_d = depth_q;
    err_d   = err_q;
    unique case (state_q)
      ACCUM: begin
        if (accept) begin
          if (bad_digit) begin
            err_d = 1'b1;
          end else begin
            // depth cap guarantees this never exceeds FANOUT**MAX_DEPTH-1
            idx_d   = IDX_W'(idx_q * IDX_W'(FANOUT)) + IDX_W'(bus.in_digit);
            depth_d = depth_q + 4'd1;
          end
          if (bus.in_last)    state_d = OUT;
          else if (bad_digit) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (accept && bus.in_last) state_d = OUT;
      end
      OUT: begin
        if (bus.out_ready) begin
          state_d = ACCUM;
          idx_d   = '0;
          depth_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  // Result fields read as zero except while a result is being offered.
  assign bus.out_valid = (state_q == OUT);
  assign bus.out_index = bus.out_valid ? idx_q   : '0;
  assign bus.out_depth = bus.out_valid ? depth_q : '0;
  assign bus.out_error = bus.out_valid ? err_q   : 1'b0;
endmodule

// File: tb/tb_hier_path_decoder.sv
// Bench for hier_path_decoder: directed paths with literal results plus random
// paths scored against a whole-path reference model.
module tb_hier_path_decoder;
  localparam int FANOUT    = 5;
  localparam int MAX_DEPTH = 9;
  localparam int DIGIT_W   = 4;
  localparam int IDX_W     = 21;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic [3:0]       depth;
    logic             err;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   vectors    = 0;
  int   miscompares = 0;
  int   rdy_mode   = 0;  // 0: always ready, 1: random, 2: stalled
  res_t exp_q[$];

  always #5 clk = ~clk;

  hier_path_decoder_if #(.DIGIT_W(DIGIT_W), .IDX_W(IDX_W)) bus ();

  hier_path_decoder #(
    .FANOUT(FANOUT), .MAX_DEPTH(MAX_DEPTH), .DIGIT_W(DIGIT_W), .IDX_W(IDX_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: the result is the index of the longest legal prefix (cut at the
  // first bad digit or at MAX_DEPTH), evaluated as a base-FANOUT number.
  function automatic res_t model(input int d[$]);
    res_t   r;
    int     p;
    bit     found;
    longint sum;
    p = d.size();
    found = 1'b0;
    for (int k = 0; k < d.size(); k++) begin
      if (!found && (d[k] >= FANOUT || k >= MAX_DEPTH)) begin
        p = k;
        found = 1'b1;
      end
    end
    sum = 0;
    for (int k = 0; k < p; k++) sum += longint'(d[k]) * longint'(FANOUT ** (p - 1 - k));
    r.idx   = IDX_W'(sum);
    r.depth = 4'(p);
    r.err   = found;
    return r;
  endfunction

  task automatic expect_lit(input int idx, input int depth, input bit err);
    res_t e;
    e.idx   = IDX_W'(idx);
    e.depth = 4'(depth);
    e.err   = err;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 after the final digit is taken.
  task automatic send_path(input int d[$], input bit with_last, input bit gaps);
    bit acc;
    int guard;
    for (int k = 0; k < d.size(); k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          bus.in_valid = 1'b0;
          bus.in_digit = DIGIT_W'($urandom);
          bus.in_last  = 1'($urandom);
          @(posedge clk); #1;
        end
      end
      bus.in_valid = 1'b1;
      bus.in_digit = DIGIT_W'(d[k]);
      bus.in_last  = with_last && (k == d.size() - 1);
      guard = 0;
      acc   = 1'b0;
      while (!acc && guard < 200) begin
        @(negedge clk);
        acc = bus.in_ready;
        @(posedge clk); #1;
        guard++;
      end
      if (!acc) begin
        vectors++;
        miscompares++;
        $display("FAIL in_ready_timeout: got 0, want 1 within 200 cycles");
      end
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() > 0 && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    if (exp_q.size() > 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: got %0d pending, want 0", exp_q.size());
    end
  endtask

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = 1'b0;
    endcase
  end

  // Single checker: every non-reset cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready_vs_out_valid", 32'(bus.in_ready), 32'(!bus.out_valid));
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_out: got out_valid=1, want no result pending");
        end else begin
          chk("out_index", 32'(bus.out_index), 32'(exp_q[0].idx));
          chk("out_depth", 32'(bus.out_depth), 32'(exp_q[0].depth));
          chk("out_error", 32'(bus.out_error), 32'(exp_q[0].err));
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int q[$];
    int n;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_digit = '0;
    bus.in_last  = 1'b0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", 32'(bus.out_valid), 0);
    chk("post_rst_out_index", 32'(bus.out_index), 0);
    chk("post_rst_out_depth", 32'(bus.out_depth), 0);
    chk("post_rst_out_error", 32'(bus.out_error), 0);
    chk("post_rst_in_ready",  32'(bus.in_ready), 1);
    @(posedge clk); #1;

    // Full depth, latency and recovery
    rdy_mode = 0;
    q = '{0, 0, 0, 0, 0, 0, 1, 0, 3};
    chk("model_pin_full", 32'(model(q).idx), 28);
    expect_lit(28, 9, 0);
    send_path(q, 1'b1, 1'b0);
    @(negedge clk);
    chk("latency_out_valid", 32'(bus.out_valid), 1);
    @(negedge clk);
    chk("recover_in_ready", 32'(bus.in_ready), 1);
    @(posedge clk); #1;

    q = '{4};
    expect_lit(4, 1, 0);
    send_path(q, 1'b1, 1'b0);
    drain();
    q = '{5};
    expect_lit(0, 0, 1);
    send_path(q, 1'b1, 1'b0);
    drain();

    q = '{2, 1, 7, 3, 0};
    chk("model_pin_drain", 32'(model(q).idx), 11);
    expect_lit(11, 2, 1);
    send_path(q, 1'b1, 1'b0);
    drain();

    q.delete();
    for (int k = 0; k < 10; k++) q.push_back(1);
    chk("model_pin_overdepth", 32'(model(q).idx), 488281);
    expect_lit(488281, 9, 1);
    send_path(q, 1'b1, 1'b0);
    drain();

    // Backpressure: stall 5 cycles, release on the 6th
    rdy_mode = 2;
    @(posedge clk); #1;
    q = '{3};
    expect_lit(3, 1, 0);
    send_path(q, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_out_valid", 32'(bus.out_valid), 1);
      chk("stall_in_ready",  32'(bus.in_ready), 0);
    end
    rdy_mode = 0;
    @(negedge clk);
    chk("release_out_valid", 32'(bus.out_valid), 1);
    @(negedge clk);
    chk("release_in_ready", 32'(bus.in_ready), 1);
    @(posedge clk); #1;

    // Reset mid-path
    q = '{1, 2};
    send_path(q, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 32'(bus.in_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_out_valid", 32'(bus.out_valid), 0);
    chk("midrst_out_index", 32'(bus.out_index), 0);
    chk("midrst_out_depth", 32'(bus.out_depth), 0);
    chk("midrst_out_error", 32'(bus.out_error), 0);
    @(posedge clk); #1;
    q = '{3};
    expect_lit(3, 1, 0);
    send_path(q, 1'b1, 1'b0);
    drain();

    // Random paths with input gaps and random consumer stalls
    rdy_mode = 1;
    for (int p = 0; p < 200; p++) begin
      q.delete();
      n = $urandom_range(1, 11);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 5) == 0) q.push_back($urandom_range(FANOUT, 15));
        else                           q.push_back($urandom_range(0, FANOUT - 1));
      end
      exp_q.push_back(model(q));
      send_path(q, 1'b1, 1'b1);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
